// File: rtl/mips_div_ctrl.sv
// EX-stage controller for the iterative mips_div divider: latches operands, runs the
// start/annul handshake, stalls EX and delivers a one-shot HI/LO write. Optional macro: MIPS_DIV_ZERO_FAST_EN.
module mips_div_ctrl #(
    parameter int OPDATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        div_req_i,
    input  logic                        div_signed_i,
    input  logic [OPDATA_WIDTH-1:0]     rs_data_i,
    input  logic [OPDATA_WIDTH-1:0]     rt_data_i,
    input  logic                        flush_i,
    input  logic                        stall_i,
    output logic                        div_start_o,
    output logic                        div_annul_o,
    output logic                        div_signed_o,
    output logic [OPDATA_WIDTH-1:0]     div_op1_o,
    output logic [OPDATA_WIDTH-1:0]     div_op2_o,
    input  logic [2*OPDATA_WIDTH-1:0]   div_result_i,
    input  logic                        div_valid_i,
    output logic                        stallreq_o,
    output logic                        whilo_o,
    output logic [OPDATA_WIDTH-1:0]     hi_o,
    output logic [OPDATA_WIDTH-1:0]     lo_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic                    signed_r;
    logic [OPDATA_WIDTH-1:0] op1_r;
    logic [OPDATA_WIDTH-1:0] op2_r;
    logic [OPDATA_WIDTH-1:0] hi_r;
    logic [OPDATA_WIDTH-1:0] lo_r;
    logic                    in_idle;
    logic                    in_busy;
    logic                    in_done;
    logic                    req_ok;
    logic                    zero_fast;

    assign in_idle = (state == IDLE);
    assign in_busy = (state == BUSY);
    assign in_done = (state == DONE);
    assign req_ok  = div_req_i & ~flush_i;

`ifdef MIPS_DIV_ZERO_FAST_EN
    assign zero_fast = (rt_data_i == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_ok) state_nxt = zero_fast ? DONE : BUSY;
            BUSY: begin
                // A flush coinciding with the divider result drops the result.
                if (flush_i)          state_nxt = IDLE;
                else if (div_valid_i) state_nxt = DONE;
            end
            DONE: if (~stall_i | flush_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            signed_r <= 1'b0;
            op1_r    <= '0;
            op2_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            state <= state_nxt;
            if (in_idle && req_ok) begin
                signed_r <= div_signed_i;
                op1_r    <= rs_data_i;
                op2_r    <= rt_data_i;
                if (zero_fast) begin
                    hi_r <= '0;
                    lo_r <= '0;
                end
            end
            if (in_busy && !flush_i && div_valid_i) begin
                hi_r <= div_result_i[2*OPDATA_WIDTH-1:OPDATA_WIDTH];
                lo_r <= div_result_i[OPDATA_WIDTH-1:0];
            end
        end
    end

    assign div_start_o  = in_busy & ~flush_i;
    assign div_annul_o  = in_busy & flush_i;
    assign div_signed_o = signed_r;
    assign div_op1_o    = op1_r;
    assign div_op2_o    = op2_r;
    // Gated by reset so the combinational request path is also quiet while reset is held.
    assign stallreq_o   = ~rst_n & ((in_idle & req_ok) | in_busy);
    assign whilo_o      = in_done & ~flush_i;
    assign hi_o         = hi_r;
    assign lo_o         = lo_r;

endmodule

// File: tb/tb_mips_div_ctrl.sv
// Bench for mips_div_ctrl: a behavioural divider answers the start handshake after a
// programmable latency; expected HI/LO come from plain arithmetic on the requested operands.
module tb_mips_div_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           div_req_i = 1'b0;
    logic           div_signed_i = 1'b0;
    logic [W-1:0]   rs_data_i = '0;
    logic [W-1:0]   rt_data_i = '0;
    logic           flush_i = 1'b0;
    logic           stall_i = 1'b0;
    logic           div_start_o;
    logic           div_annul_o;
    logic           div_signed_o;
    logic [W-1:0]   div_op1_o;
    logic [W-1:0]   div_op2_o;
    logic [2*W-1:0] div_result_i;
    logic           div_valid_i;
    logic           stallreq_o;
    logic           whilo_o;
    logic [W-1:0]   hi_o;
    logic [W-1:0]   lo_o;

    int vectors = 0;
    int miscompares = 0;
    int div_lat = 2;
    int div_cnt;

    mips_div_ctrl #(.OPDATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .flush_i(flush_i), .stall_i(stall_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_result_i(div_result_i),
        .div_valid_i(div_valid_i), .stallreq_o(stallreq_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        if (b == '0) return '0;
        if (s) begin
            sa = a;
            sb = b;
            return {sa % sb, sa / sb};
        end
        return {a % b, a / b};
    endfunction

    // Divider stand-in: result after div_lat cycles of start, held until start drops.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_valid_i  <= 1'b0;
            div_cnt      <= 0;
            div_result_i <= '0;
        end else if (!div_start_o) begin
            div_valid_i <= 1'b0;
            div_cnt     <= 0;
        end else if (!div_valid_i) begin
            if (div_cnt >= div_lat) begin
                div_valid_i  <= 1'b1;
                div_result_i <= ref_div(div_signed_o, div_op1_o, div_op2_o);
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input int nstall, input logic [W-1:0] exh, input logic [W-1:0] exl, input string nm);
        logic saw_v;
        logic done_ok;
        logic fast;
        tick();
        div_lat = lat;
        div_req_i = 1'b1; div_signed_i = s; rs_data_i = a; rt_data_i = b;
        flush_i = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({stallreq_o, div_start_o, whilo_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s req_cycle: stallreq/start/whilo got %b expected 100", nm, {stallreq_o, div_start_o, whilo_o});
        end
        tick();
        rs_data_i = $urandom;
        rt_data_i = $urandom;
        fast = 1'b0;
`ifdef MIPS_DIV_ZERO_FAST_EN
        fast = (b == '0);
`endif
        if (!fast) begin
            done_ok = 1'b0;
            for (int n = 0; n < 100 && !done_ok; n++) begin
                @(negedge clk);
                vectors++;
                if ({div_start_o, div_annul_o, stallreq_o, whilo_o, div_signed_o, div_op1_o, div_op2_o} !== {4'b1010, s, a, b}) begin
                    miscompares++;
                    $display("FAIL %s busy: start/annul/stallreq/whilo/sgn/op1/op2 got %b_%b_%h_%h expected %b_%b_%h_%h", nm,
                             {div_start_o, div_annul_o, stallreq_o, whilo_o}, div_signed_o, div_op1_o, div_op2_o,
                             4'b1010, s, a, b);
                end
                saw_v = div_valid_i;
                tick();
                if (saw_v) done_ok = 1'b1;
            end
            vectors++;
            if (!done_ok) begin
                miscompares++;
                $display("FAIL %s timeout: no divider result within 100 cycles got 0 expected 1", nm);
            end
        end
        for (int i = 0; i <= nstall; i++) begin
            stall_i = (i < nstall);
            @(negedge clk);
            vectors++;
            if ({whilo_o, stallreq_o, div_start_o, div_annul_o, hi_o, lo_o} !== {4'b1000, exh, exl}) begin
                miscompares++;
                $display("FAIL %s done: whilo/stallreq/start/annul hi lo got %b %h %h expected 1000 %h %h", nm,
                         {whilo_o, stallreq_o, div_start_o, div_annul_o}, hi_o, lo_o, exh, exl);
            end
            tick();
        end
        div_req_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({whilo_o, stallreq_o, div_start_o, div_annul_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s idle_after: whilo/stallreq/start/annul got %b expected 0000", nm,
                     {whilo_o, stallreq_o, div_start_o, div_annul_o});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        vectors++;
        if ({div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o, stallreq_o, whilo_o, hi_o, lo_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: outputs nonzero got start=%b annul=%b hi=%h lo=%h expected all 0",
                     div_start_o, div_annul_o, hi_o, lo_o);
        end
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_vectors();
        run_div(1'b1, 32'd100, 32'd7, 4, 0, 32'd2, 32'd14, "div_100_7");
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7_2");
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 0, 0, 32'd1, 32'h7FFFFFFC, "divu_big_2");
        run_div(1'b0, 32'd1000, 32'd33, 5, 3, 32'd10, 32'd30, "stall3");
        run_div(1'b0, 32'd5, 32'd0, 3, 0, 32'd0, 32'd0, "divu_5_0");
    endtask

    task automatic test_flush();
        tick();
        div_lat = 40;
        div_req_i = 1'b1; div_signed_i = 1'b0; rs_data_i = 32'd20; rt_data_i = 32'd4;
        tick();
        repeat (10) tick();
        flush_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({div_annul_o, div_start_o, stallreq_o, whilo_o} !== 4'b1010) begin
            miscompares++;
            $display("FAIL flush_busy: annul/start/stallreq/whilo got %b expected 1010", {div_annul_o, div_start_o, stallreq_o, whilo_o});
        end
        tick();
        flush_i = 1'b0;
        div_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({div_annul_o, div_start_o, stallreq_o, whilo_o} !== 4'b0000) begin
                miscompares++;
                $display("FAIL flush_idle: annul/start/stallreq/whilo got %b expected 0000", {div_annul_o, div_start_o, stallreq_o, whilo_o});
            end
            tick();
        end
        run_div(1'b0, 32'd9, 32'd3, 3, 0, 32'd0, 32'd3, "divu_9_3");
        // Flush in IDLE blocks the request entirely.
        tick();
        div_req_i = 1'b1; flush_i = 1'b1; rs_data_i = 32'd77; rt_data_i = 32'd7;
        @(negedge clk);
        vectors++;
        if ({stallreq_o, div_start_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_idle_req: stallreq/start got %b expected 00", {stallreq_o, div_start_o});
        end
        tick();
        div_req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({div_start_o, div_op1_o} !== {1'b0, 32'd9}) begin
            miscompares++;
            $display("FAIL flush_no_latch: start/op1 got %b %h expected 0 %h", div_start_o, div_op1_o, 32'd9);
        end
    endtask

    task automatic test_flush_edges();
        int n;
        // Flush in the same cycle as the divider result: result dropped.
        tick();
        div_lat = 1;
        div_req_i = 1'b1; div_signed_i = 1'b1; rs_data_i = 32'd50; rt_data_i = 32'd5;
        tick();
        for (n = 0; n < 50 && !div_valid_i; n++) tick();
        flush_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({div_valid_i, div_annul_o, div_start_o} !== 3'b110) begin
            miscompares++;
            $display("FAIL flush_valid: valid/annul/start got %b expected 110", {div_valid_i, div_annul_o, div_start_o});
        end
        tick();
        flush_i = 1'b0; div_req_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({whilo_o, stallreq_o, div_start_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_valid_drop: whilo/stallreq/start got %b expected 000", {whilo_o, stallreq_o, div_start_o});
        end
        // Flush in DONE suppresses the write and leaves DONE despite stall.
        tick();
        div_req_i = 1'b1;
        tick();
        for (n = 0; n < 50 && !div_valid_i; n++) tick();
        tick();
        flush_i = 1'b1; stall_i = 1'b1;
        @(negedge clk);
        vectors++;
        if ({whilo_o, stallreq_o, div_start_o, hi_o, lo_o} !== {3'b000, 32'd0, 32'd10}) begin
            miscompares++;
            $display("FAIL flush_done: whilo/stallreq/start hi lo got %b %h %h expected 000 0 a",
                     {whilo_o, stallreq_o, div_start_o}, hi_o, lo_o);
        end
        tick();
        flush_i = 1'b0; stall_i = 1'b0; div_req_i = 1'b0;
        @(negedge clk);
        vectors++;
        if ({whilo_o, stallreq_o, div_start_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_done_exit: whilo/stallreq/start got %b expected 000", {whilo_o, stallreq_o, div_start_o});
        end
    endtask

    task automatic test_reset_mid();
        tick();
        div_lat = 30;
        div_req_i = 1'b1; div_signed_i = 1'b1; rs_data_i = 32'd100; rt_data_i = 32'd7;
        tick();
        tick();
        #1 rst_n = 1'b1;
        #1;
        vectors++;
        if ({div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o, stallreq_o, whilo_o, hi_o, lo_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs got start=%b stallreq=%b op1=%h expected all 0", div_start_o, stallreq_o, div_op1_o);
        end
        div_req_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        run_div(1'b1, 32'd100, 32'd7, 3, 0, 32'd2, 32'd14, "after_reset");
    endtask

    task automatic test_random();
        logic         s;
        logic [W-1:0] a, b;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
            if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            exp = ref_div(s, a, b);
            run_div(s, a, b, $urandom_range(0, 8), $urandom_range(0, 2), exp[2*W-1:W], exp[W-1:0], "random");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_flush();
        test_flush_edges();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_div_ctrl.md
# mips_div_ctrl

EX-stage divide controller between pipeline decode/EX and the iterative `mips_div` divider. Accepts DIV/DIVU requests from EX and latches the operands so they stay stable for the whole division. Drives the divider's start/annul handshake, stalls the pipeline while the divider runs, and presents the finished remainder/quotient as a one-shot HI/LO write.

## Interface
Parameters:
- `OPDATA_WIDTH`, 32, operand width; HI/LO width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  **asynchronous, active-high** reset (asserted when 1).
- `div_req_i`  in  1  EX holds a DIV/DIVU instruction.
- `div_signed_i`  in  1  1 = DIV (signed), 0 = DIVU.
- `rs_data_i`  in  W  dividend.
- `rt_data_i`  in  W  divisor.
- `flush_i`  in  1  pipeline flush (exception/eret).
- `stall_i`  in  1  downstream stage stalled; EX cannot retire.
- `div_start_o`  out  1  divider start, held until done.
- `div_annul_o`  out  1  divider cancel.
- `div_signed_o`  out  1  latched sign mode.
- `div_op1_o`  out  W  latched dividend.
- `div_op2_o`  out  W  latched divisor.
- `div_result_i`  in  2W  divider result, {remainder, quotient}.
- `div_valid_i`  in  1  divider result valid (level).
- `stallreq_o`  out  1  stall request to pipeline control.
- `whilo_o`  out  1  HI/LO write enable.
- `hi_o`  out  W  remainder.
- `lo_o`  out  W  quotient.

## Operation
FSM states: `IDLE`, `BUSY`, `DONE`. All registers are async-reset to 0 and state resets to `IDLE`, so every output is 0 in reset.

- **IDLE:**
  - `div_req_i & !flush_i` → latch `rs_data_i`, `rt_data_i`, `div_signed_i` into operand registers; go to `BUSY`.
  - `flush_i` takes priority: stay in `IDLE`, no latch.
- **BUSY:**
  - `div_start_o` = 1; operand outputs come only from the latched registers and never change while in `BUSY`.
  - `flush_i` → `div_annul_o` = 1 combinationally and `div_start_o` = 0 in that cycle; go to `IDLE` and discard the operation.
  - Else, if `div_valid_i` = 1 → capture `hi` ← `div_result_i[2W-1:W]`, `lo` ← `div_result_i[W-1:0]`; go to `DONE`.
  - `flush_i` and `div_valid_i` in the same cycle: flush wins and the result is dropped.
- **DONE:**
  - `div_start_o` = 0, which returns the divider to free.
  - `whilo_o` = `!flush_i`.
  - `!stall_i | flush_i` → go to `IDLE`.
  - `stall_i` → stay in `DONE`, holding `hi_o`/`lo_o`/`whilo_o`.
  - `div_req_i` is ignored in `DONE`.
- `stallreq_o` = `(IDLE & div_req_i & !flush_i) | BUSY`. It is combinational and is 0 in `DONE`.
- `div_annul_o` = `BUSY & flush_i`; 0 in all other states.
- The controller does no sign or width arithmetic. Signed fix-up is the divider's job; the controller only passes the mode through.

## Timing
- Request cycle T (IDLE, stall asserted) → `div_start_o` high from T+1.
- `div_valid_i` sampled high at cycle V → `whilo_o` high at V+1.
- Total EX stall = 1 + (cycles spent in `BUSY`); the instruction leaves EX at the end of the `DONE` cycle.
- `whilo_o` pulses for exactly one cycle when `stall_i` = 0.
- Back-to-back divides: at least one `IDLE` cycle separates consecutive operations. This guarantees the divider has seen start low and returned to free.
- Reset mid-operation: immediate return to `IDLE`, all outputs 0, the in-flight result is lost. The divider shares the same reset.

## Configuration
- `MIPS_DIV_ZERO_FAST_EN` defined:
  - In `IDLE`, `div_req_i & !flush_i & rt_data_i == 0` goes straight to `DONE` with `hi` = `lo` = 0.
  - `div_start_o` never asserts for that operation; stall is 1 cycle.
- Undefined: divide-by-zero goes through `BUSY` like any other divide and takes the divider's result (0/0).

## Test plan
- DIV 100/7, no flush/stall → `div_start_o` held until `div_valid_i`; one-cycle `whilo_o` with `lo_o`=14, `hi_o`=2; `stallreq_o` low in `DONE`.
- DIV 0xFFFFFFF9/2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → `lo_o`=0x7FFFFFFC, `hi_o`=1.
- `flush_i` pulsed 10 cycles into `BUSY` → `div_annul_o`=1 for that cycle, `div_start_o`=0, return to `IDLE`, no `whilo_o`; a following DIVU 9/3 gives `lo_o`=3, `hi_o`=0.
- `stall_i`=1 for 3 cycles on entering `DONE` → `whilo_o`/`hi_o`/`lo_o` held 3 cycles, then `IDLE`; `rs_data_i` changed during `BUSY` does not alter `div_op1_o` or the result.
- DIVU 5/0 → `hi_o`=`lo_o`=0.
  - With the macro: `div_start_o` never high, `whilo_o` at T+1.
  - Without the macro: `div_start_o` asserts and the result arrives via `div_valid_i`.
- Reset asserted during `BUSY` → all outputs 0 asynchronously; after release, a DIV 100/7 completes normally.
